// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and request error checks for the load/store initiator.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } lsu_state_t;

    function automatic logic lsu_req_err(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [31:0] mem_words,
        input logic        trap_misalign
    );
        logic illegal;
        logic misaligned;
        logic out_of_range;
        if (we) begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                        funct3 == F3_BU || funct3 == F3_HU);
        end
        misaligned   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                       (funct3 == F3_W && addr[1:0] != 2'b00);
        out_of_range = {2'b00, addr[31:2]} >= mem_words;
        return illegal | out_of_range | (trap_misalign & misaligned);
    endfunction

    // Non-trapping builds silently drop the low offset bits a wider access cannot use.
    function automatic logic [1:0] lsu_align_offset(
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        case (funct3)
            F3_H, F3_HU: return {addr_lo[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = word[{offset[1], 4'b0000} +: 16];

        load_val = '0;
        case (funct3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_val = word;
            F3_BU:   load_val = {24'h000000, byte_sel};
            F3_HU:   load_val = {16'h0000, half_sel};
            default: load_val = '0;
        endcase

        store_word = word;
        case (funct3)
            F3_B:    store_word[{offset, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator driving a word-indexed async-read memory port.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses report resp_err instead of aligning.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP_MISALIGN = 1'b1;
`else
    localparam logic TRAP_MISALIGN = 1'b0;
`endif

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;
    logic [31:0] merge_q;
    logic        err_q;

    logic        access_err;
    logic [1:0]  offset;
    logic [31:0] lane_word;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        we_raw;
    logic [31:0] wd_raw;

    assign access_err = lsu_req_err(we_q, f3_q, addr_q, 32'(MEM_WORDS), TRAP_MISALIGN);
    assign offset     = lsu_align_offset(f3_q, addr_q[1:0]);
    // Loads extract from the live read; sub-word stores merge into the word captured in ACCESS.
    assign lane_word  = (state_q == WRITE) ? merge_q : mem_rd;

    lsu_lane_align u_align (
        .word       (lane_word),
        .offset     (offset),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_a      = '0;
        we_raw     = 1'b0;
        wd_raw     = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_a = {2'b00, addr_q[31:2]};
                if (access_err || !we_q) begin
                    state_d = RESP;
                end else if (f3_q == F3_W) begin
                    we_raw  = 1'b1;
                    wd_raw  = wdata_q;
                    state_d = RESP;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_a   = {2'b00, addr_q[31:2]};
                we_raw  = 1'b1;
                wd_raw  = store_word;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the write combinationally so a reset landing on WRITE leaves memory intact.
    assign mem_we = we_raw & ~rst;
    assign mem_wd = mem_we ? wd_raw : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            merge_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ACCESS) begin
                err_q    <= access_err;
                result_q <= (!access_err && !we_q) ? load_val : '0;
                if (!access_err && we_q && f3_q != F3_W) begin
                    merge_q <= mem_rd;
                end
            end
        end
    end

    assign resp_rdata = result_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized self-checking bench for lsu_mem_initiator against a behavioural memory model.
module tb_lsu_mem_initiator;

    localparam int unsigned TB_WORDS = 256;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem     [TB_WORDS];
    logic [31:0] ref_mem [TB_WORDS];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  wmask;
        logic [31:0] wr_a;
        logic [31:0] wr_d;
        logic        busy_ok;
        logic        wd_ok;
        logic        idle_a_ok;
        logic        ready_after;
    } obs_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  wmask;
        logic [31:0] wr_a;
        logic [31:0] wr_d;
    } exp_t;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.MEM_WORDS(TB_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = (mem_a < TB_WORDS) ? mem[mem_a[7:0]] : '0;

    always @(posedge clk) begin
        if (mem_we && mem_a < TB_WORDS) mem[mem_a[7:0]] <= mem_wd;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Expected outcome of one request, derived from the access rules; updates ref_mem for stores.
    function automatic exp_t ref_model(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int unsigned idx;
        int unsigned off;
        bit is_half, is_word, legal, mis;
        logic [31:0] w, b, h, m;
        e.lat = 2; e.rdata = '0; e.err = 1'b0; e.wmask = '0; e.wr_a = '0; e.wr_d = '0;
        idx = addr >> 2;
        off = addr & 3;
        is_half = (f3 == 3'd1) || (!we && f3 == 3'd5);
        is_word = (f3 == 3'd2);
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis = (is_half && (off % 2) != 0) || (is_word && off != 0);
        if (!legal || idx >= TB_WORDS || (TRAP && mis)) begin
            e.err = 1'b1;
            return e;
        end
        if (is_half) off = off & 2;
        if (is_word) off = 0;
        w = ref_mem[idx];
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (8 * off)) & 32'hFFFF;
        if (!we) begin
            case (f3)
                3'd0: e.rdata = (b >= 128) ? (b | 32'hFFFFFF00) : b;
                3'd1: e.rdata = (h >= 32768) ? (h | 32'hFFFF0000) : h;
                3'd2: e.rdata = w;
                3'd4: e.rdata = b;
                default: e.rdata = h;
            endcase
        end else begin
            e.wr_a = idx;
            if (f3 == 3'd2) begin
                e.wmask = 8'b0000_0010;
                e.wr_d  = wdata;
            end else begin
                e.lat   = 3;
                e.wmask = 8'b0000_0100;
                m = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
                e.wr_d = (w & ~m) | ((wdata << (8 * off)) & m);
            end
            ref_mem[idx] = e.wr_d;
        end
        return e;
    endfunction

    // Issues one request from IDLE (called #1 after an edge) and records what the DUT did.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output obs_t o);
        o.lat = 0; o.rdata = '0; o.err = 1'b0; o.wmask = '0; o.wr_a = '0; o.wr_d = '0;
        o.busy_ok = 1'b1; o.wd_ok = 1'b1; o.idle_a_ok = 1'b1; o.ready_after = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Junk request held during busy cycles must be ignored.
        req_we = ~we; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 6; k++) begin
            if (mem_we) begin
                o.wmask[k] = 1'b1;
                o.wr_a = mem_a;
                o.wr_d = mem_wd;
            end else if (mem_wd !== 32'h0) begin
                o.wd_ok = 1'b0;
            end
            if (req_ready) o.busy_ok = 1'b0;
            if (resp_valid) begin
                o.lat = k; o.rdata = resp_rdata; o.err = resp_err;
                if (mem_a !== 32'h0) o.idle_a_ok = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (o.lat != 0) begin
            @(posedge clk); #1;
            o.ready_after = req_ready & ~resp_valid;
            if (mem_a !== 32'h0) o.idle_a_ok = 1'b0;
        end
    endtask

    task automatic poke(input int unsigned idx, input logic [31:0] v);
        mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready/valid/we=%b%b%b expected 100", req_ready, resp_valid, mem_we);
        end
        vectors++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || mem_a !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: rdata=%h err=%b mem_a=%h expected 0/0/0", resp_rdata, resp_err, mem_a);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        exp_t e;
        logic [31:0] want [4];
        logic [2:0]  f3s  [4];
        logic [31:0] ads  [4];
        want = '{32'hFFFFFFAA, 32'h000000AA, 32'h00008899, 32'hFFFF8899};
        f3s  = '{3'b000, 3'b100, 3'b101, 3'b001};
        ads  = '{32'h11, 32'h11, 32'h12, 32'h12};
        poke(4, 32'h8899AABB);
        for (int i = 0; i < 4; i++) begin
            e = ref_model(1'b0, f3s[i], ads[i], 32'h0);
            run_req(1'b0, f3s[i], ads[i], 32'h0, o);
            vectors++;
            if (o.rdata !== want[i] || o.err !== 1'b0 || o.lat != 2) begin
                miscompares++;
                $display("FAIL load_%0d: rdata=%h err=%b lat=%0d expected %h 0 2", i, o.rdata, o.err, o.lat, want[i]);
            end
            vectors++;
            if (o.wmask !== 8'h0 || !o.busy_ok || !o.ready_after || e.rdata !== want[i]) begin
                miscompares++;
                $display("FAIL load_ctl_%0d: wmask=%h busy_ok=%b ready_after=%b expected 00 1 1", i, o.wmask, o.busy_ok, o.ready_after);
            end
        end
    endtask

    task automatic test_subword_store();
        obs_t o;
        exp_t e;
        poke(2, 32'h11223344);
        e = ref_model(1'b1, 3'b000, 32'h0A, 32'hFFFFFFEE);
        run_req(1'b1, 3'b000, 32'h0A, 32'hFFFFFFEE, o);
        vectors++;
        if (mem[2] !== 32'h11EE3344 || e.wr_d !== 32'h11EE3344) begin
            miscompares++;
            $display("FAIL sb_merge: mem=%h expected 11ee3344", mem[2]);
        end
        vectors++;
        if (o.lat != 3 || o.wmask !== 8'b0000_0100 || o.wr_a !== 32'd2 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL sb_timing: lat=%0d wmask=%b wr_a=%0d err=%b rdata=%h expected 3 00000100 2 0 0",
                     o.lat, o.wmask, o.wr_a, o.err, o.rdata);
        end
    endtask

    task automatic test_sw_lw();
        obs_t o;
        exp_t e;
        e = ref_model(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        run_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, o);
        vectors++;
        if (o.lat != 2 || o.wmask !== 8'b0000_0010 || o.wr_a !== 32'd8 || o.wr_d !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL sw: lat=%0d wmask=%b wr_a=%0d wr_d=%h expected 2 00000010 8 deadbeef", o.lat, o.wmask, o.wr_a, o.wr_d);
        end
        e = ref_model(1'b0, 3'b010, 32'h20, 32'h0);
        run_req(1'b0, 3'b010, 32'h20, 32'h0, o);
        vectors++;
        if (o.rdata !== 32'hDEADBEEF || o.err !== 1'b0 || e.rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL lw_after_sw: rdata=%h err=%b expected deadbeef 0", o.rdata, o.err);
        end
    endtask

    task automatic test_errors();
        obs_t o;
        exp_t e;
        logic [31:0] want_misalign;
        logic        we_s [4];
        logic [2:0]  f3_s [4];
        logic [31:0] ad_s [4];
        want_misalign = TRAP ? 32'h0 : 32'hDEADBEEF;
        e = ref_model(1'b0, 3'b010, 32'h22, 32'h0);
        run_req(1'b0, 3'b010, 32'h22, 32'h0, o);
        vectors++;
        if (o.err !== TRAP || o.rdata !== want_misalign || o.wmask !== 8'h0 || o.lat != 2) begin
            miscompares++;
            $display("FAIL lw_misalign: err=%b rdata=%h wmask=%h lat=%0d expected %b %h 00 2",
                     o.err, o.rdata, o.wmask, o.lat, TRAP, want_misalign);
        end
        we_s = '{1'b0, 1'b0, 1'b1, 1'b1};
        f3_s = '{3'b010, 3'b011, 3'b100, 3'b010};
        ad_s = '{TB_WORDS * 4, 32'h10, 32'h10, 32'hFFFF_FFFC};
        for (int i = 0; i < 4; i++) begin
            e = ref_model(we_s[i], f3_s[i], ad_s[i], 32'h12345678);
            run_req(we_s[i], f3_s[i], ad_s[i], 32'h12345678, o);
            vectors++;
            if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.wmask !== 8'h0 || o.lat != 2 || e.err !== 1'b1) begin
                miscompares++;
                $display("FAIL err_case_%0d: err=%b rdata=%h wmask=%h lat=%0d expected 1 0 00 2",
                         i, o.err, o.rdata, o.wmask, o.lat);
            end
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        int unsigned idx;
        for (int n = 0; n < 300; n++) begin
            we    = 1'($urandom);
            f3    = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, TB_WORDS * 4 + 31));
            wdata = $urandom;
            idx   = addr >> 2;
            e = ref_model(we, f3, addr, wdata);
            run_req(we, f3, addr, wdata, o);
            vectors++;
            if (o.lat != e.lat || o.err !== e.err || o.rdata !== e.rdata || o.wmask !== e.wmask) begin
                miscompares++;
                $display("FAIL rand_%0d resp: we=%b f3=%0d addr=%h lat=%0d err=%b rdata=%h wmask=%b expected %0d %b %h %b",
                         n, we, f3, addr, o.lat, o.err, o.rdata, o.wmask, e.lat, e.err, e.rdata, e.wmask);
            end
            vectors++;
            if ((e.wmask != 0 && (o.wr_a !== e.wr_a || o.wr_d !== e.wr_d)) ||
                (idx < TB_WORDS && mem[idx] !== ref_mem[idx])) begin
                miscompares++;
                $display("FAIL rand_%0d mem: addr=%h wr_a=%h wr_d=%h expected %h %h", n, addr, o.wr_a, o.wr_d, e.wr_a, e.wr_d);
            end
            vectors++;
            if (!o.busy_ok || !o.wd_ok || !o.idle_a_ok || !o.ready_after) begin
                miscompares++;
                $display("FAIL rand_%0d ctl: busy_ok=%b wd_ok=%b idle_a_ok=%b ready_after=%b expected 1111",
                         n, o.busy_ok, o.wd_ok, o.idle_a_ok, o.ready_after);
            end
        end
    endtask

    task automatic test_reset_during_write();
        obs_t o;
        exp_t e;
        logic seen;
        poke(4, 32'h8899AABB);
        e = ref_model(1'b0, 3'b000, 32'h11, 32'h0);
        run_req(1'b0, 3'b000, 32'h11, 32'h0, o);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        vectors++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || o.rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL reset_clears: rdata=%h err=%b expected 0 0", resp_rdata, resp_err);
        end
        poke(5, 32'hCAFEF00D);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h16; req_wdata = 32'h00001234;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (mem_we !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_write_cycle: mem_we=%b expected 1", mem_we);
        end
        rst = 1'b1; #1;
        vectors++;
        if (mem_we !== 1'b0 || mem_wd !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_gates_we: mem_we=%b mem_wd=%h expected 0 0", mem_we, mem_wd);
        end
        @(posedge clk); #1; rst = 1'b0;
        vectors++;
        if (mem[5] !== 32'hCAFEF00D || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_write_suppressed: mem=%h ready=%b expected cafef00d 1", mem[5], req_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (resp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_resp: resp_valid seen=%b expected 0", seen);
        end
    endtask

    initial begin
        for (int i = 0; i < TB_WORDS; i++) poke(i, $urandom);
        test_reset();
        test_loads();
        test_subword_store();
        test_sw_lw();
        test_errors();
        test_random();
        test_reset_during_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Memory-stage load/store initiator for the RISC-V pipeline. It accepts one load or store request at a time from the MEM stage and drives the word-indexed data memory port: asynchronous read, write on the clock edge. It provides the byte and halfword semantics that the memory port lacks. Sub-word stores are done as read-modify-write, and every request returns a single-cycle response with load data or an error flag.

## Interface
Parameters:
- MEM_WORDS, 65536, number of 32-bit words in the attached memory; word index ≥ MEM_WORDS is out of range.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 access size/sign.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3; valid with resp_valid.
- mem_a  out  32  word index {2'b00, addr[31:2]}.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data (combinational from mem_a).

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and go to ACCESS.
- ACCESS:
  - Error request: go to RESP with err=1; no memory access; mem_we=0.
  - Load: sample mem_rd, extract and extend into the result register, go to RESP.
  - SW: mem_we=1, mem_wd=wdata, go to RESP.
  - SB/SH: sample mem_rd into the merge register, go to WRITE.
- WRITE: mem_we=1, mem_wd=merged word (target lane(s) replaced, other lanes preserved), go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal stores: SB 000, SH 001, SW 010. Any other code is an illegal funct3.
- Byte lanes are little-endian.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]≠0.
- Out-of-range: addr[31:2] ≥ MEM_WORDS.
- mem_a holds the latched word index in ACCESS and WRITE, and 0 otherwise.
- mem_wd is 0 whenever mem_we=0.

## Timing
- Request accepted at edge E0 (req_valid & req_ready).
- Load, SW and error requests: resp_valid in cycle E0+2 (ACCESS in E0+1). Occupancy is 3 cycles including IDLE.
- SB/SH: ACCESS in E0+1, WRITE in E0+2, resp_valid in E0+3.
- Back-to-back: req_ready returns the cycle after RESP. Throughput is one request per 3 cycles (loads) or 4 cycles (sub-word stores).
- Reset:
  - rst=1 at an edge forces IDLE.
  - Registers cleared: resp_rdata=0, resp_err=0, result and merge registers 0.
  - Outputs: resp_valid=0, req_ready=1 after reset, mem_we=0.
  - mem_we is combinationally gated by ~rst, so a reset asserted during WRITE suppresses that write. The memory word keeps its old value and no response is issued.
- req_valid during a non-IDLE state is ignored (req_ready=0). The request must be held by the source.

## Configuration
- LSU_MISALIGN_TRAP_EN
  - Defined: misaligned accesses return resp_err=1 with no memory read or write.
  - Undefined: misalignment is not an error. The effective offset is forced aligned (addr[0] cleared for halfwords, addr[1:0] cleared for words) and the access proceeds normally.
- Out-of-range and illegal-funct3 errors are unaffected by the macro.

## Structure
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum {IDLE, ACCESS, WRITE, RESP}.
  - The helper function computing the error conditions.
- Sub-module lsu_lane_align (combinational) takes the word, offset, funct3 and store data. It produces the extracted, extended load value and the merged store word. The FSM and registers stay in lsu_mem_initiator.

## Test plan
- Reset, then rst=1 held 2 cycles → req_ready=1, resp_valid=0, mem_we=0, resp_rdata=0.
- Memory word 4 = 0x8899AABB; LB addr 0x11 → resp_rdata 0xFFFFFFAA at E0+2. LBU addr 0x11 → 0x000000AA. LHU addr 0x12 → 0x00008899.
- Memory word 2 = 0x11223344; SB addr 0x0A with wdata 0xFFFFFFEE → memory reads 0x11EE3344. resp_valid at E0+3; mem_we high only in E0+2.
- SW addr 0x20 with wdata 0xDEADBEEF → mem_we at E0+1 with mem_a=8; LW addr 0x20 then returns 0xDEADBEEF.
- Error cases:
  - LW addr 0x22 → with LSU_MISALIGN_TRAP_EN: resp_err=1, resp_rdata=0, no mem_we. Without it: data of word 8.
  - Word index MEM_WORDS → resp_err=1.
  - funct3=011 → resp_err=1.
- rst asserted during the WRITE cycle of an SH → target word unchanged, no resp_valid, block back in IDLE.
